// File: rtl/per_resp_tracker.sv
// per_resp_tracker: records the peripheral index of every granted request in
// issue order and returns the matching peripheral response to the master as a
// single registered response stream. Out-of-order or untracked responses are
// dropped and raise a sticky error flag.
module per_resp_tracker #(
  parameter int unsigned PE_XBAR_N_OUPS  = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  localparam int unsigned IDX_W = (PE_XBAR_N_OUPS > 1) ? $clog2(PE_XBAR_N_OUPS) : 1,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 req_valid_i,
  input  logic [IDX_W-1:0]                     req_pe_idx_i,
  input  logic                                 req_gnt_i,
  output logic                                 req_stall_o,
  input  logic [PE_XBAR_N_OUPS-1:0]            per_r_valid_i,
  input  logic [PE_XBAR_N_OUPS*DATA_WIDTH-1:0] per_r_rdata_i,
  input  logic [PE_XBAR_N_OUPS-1:0]            per_r_opc_i,
  output logic                                 r_valid_o,
  output logic [DATA_WIDTH-1:0]                r_rdata_o,
  output logic                                 r_opc_o,
  output logic [CNT_W-1:0]                     outstanding_o,
  input  logic                                 err_clear_i,
  output logic                                 err_unexpected_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

  logic [IDX_W-1:0]          fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [CNT_W-1:0]          count_q;

  logic                      full;
  logic                      push;
  logic                      pop;
  logic                      unexpected;
  logic [IDX_W-1:0]          head_idx;
  logic [PE_XBAR_N_OUPS-1:0] head_mask;
  logic [DATA_WIDTH-1:0]     rdata_arr [PE_XBAR_N_OUPS];

  for (genvar k = 0; k < PE_XBAR_N_OUPS; k++) begin : g_unpack
    assign rdata_arr[k] = per_r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Head decode from registered state only; any valid bit outside the head
  // mask (or any bit at all while empty) is an unexpected response.
  always_comb begin
    full      = (count_q == CNT_FULL);
    push      = req_valid_i & req_gnt_i & ~full;
    head_idx  = fifo_q[rd_ptr_q];
    head_mask = '0;
    if (count_q != '0) begin
      head_mask[head_idx] = 1'b1;
    end
    pop        = |(per_r_valid_i & head_mask);
    unexpected = |(per_r_valid_i & ~head_mask);
  end

  assign req_stall_o   = full;
  assign outstanding_o = count_q;

  // Index storage: write the granted peripheral index at the write pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= req_pe_idx_i;
    end
  end

  // Pointers wrap explicitly at the last entry so non-power-of-2 depths work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Occupancy count; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered response stream; data and error flag hold between pops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_rdata_o <= '0;
      r_opc_o   <= 1'b0;
    end else begin
      r_valid_o <= pop;
      if (pop) begin
        r_rdata_o <= rdata_arr[head_idx];
        r_opc_o   <= per_r_opc_i[head_idx];
      end
    end
  end

  // Sticky unexpected-response flag; a new event wins over a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_unexpected_o <= 1'b0;
    end else if (unexpected) begin
      err_unexpected_o <= 1'b1;
    end else if (err_clear_i) begin
      err_unexpected_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_per_resp_tracker.sv
// Bench for per_resp_tracker: two instances (depth 4 and depth 3) share one
// stimulus stream and are compared every cycle against queue-based models.
module tb_per_resp_tracker;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int D0 = 4;
  localparam int D1 = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid, req_gnt, err_clear;
  logic [2:0]    req_idx;
  logic [N-1:0]  per_valid, per_opc;
  logic [N*DW-1:0] per_rdata;

  logic          stall0, rv0, opc0, err0;
  logic [DW-1:0] rd0;
  logic [2:0]    out0;
  logic          stall1, rv1, opc1, err1;
  logic [DW-1:0] rd1;
  logic [1:0]    out1;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural models: one queue of outstanding indices per instance.
  int            mq [2][$];
  logic          m_rv  [2];
  logic [DW-1:0] m_rd  [2];
  logic          m_opc [2];
  logic          m_err [2];

  per_resp_tracker #(.PE_XBAR_N_OUPS(N), .MAX_OUTSTANDING(D0), .DATA_WIDTH(DW)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_pe_idx_i(req_idx),
    .req_gnt_i(req_gnt), .req_stall_o(stall0), .per_r_valid_i(per_valid),
    .per_r_rdata_i(per_rdata), .per_r_opc_i(per_opc), .r_valid_o(rv0),
    .r_rdata_o(rd0), .r_opc_o(opc0), .outstanding_o(out0),
    .err_clear_i(err_clear), .err_unexpected_o(err0)
  );

  per_resp_tracker #(.PE_XBAR_N_OUPS(N), .MAX_OUTSTANDING(D1), .DATA_WIDTH(DW)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_pe_idx_i(req_idx),
    .req_gnt_i(req_gnt), .req_stall_o(stall1), .per_r_valid_i(per_valid),
    .per_r_rdata_i(per_rdata), .per_r_opc_i(per_opc), .r_valid_o(rv1),
    .r_rdata_o(rd1), .r_opc_o(opc1), .outstanding_o(out1),
    .err_clear_i(err_clear), .err_unexpected_o(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update on each clock edge or reset assertion.
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_rv[i] = 1'b0; m_rd[i] = '0; m_opc[i] = 1'b0; m_err[i] = 1'b0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          mq[i].delete();
          m_rv[i] = 1'b0; m_rd[i] = '0; m_opc[i] = 1'b0; m_err[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          int  cnt;
          int  hd;
          bit  pop;
          bit  unexp;
          cnt   = mq[i].size();
          hd    = -1;
          pop   = 1'b0;
          unexp = 1'b0;
          if (cnt != 0) begin
            hd  = mq[i][0];
            pop = per_valid[hd];
          end
          for (int k = 0; k < N; k++) begin
            if (per_valid[k] && k != hd) unexp = 1'b1;
          end
          m_rv[i] = pop;
          if (pop) begin
            m_rd[i]  = per_rdata[hd*DW +: DW];
            m_opc[i] = per_opc[hd];
            void'(mq[i].pop_front());
          end
          if (unexp) m_err[i] = 1'b1;
          else if (err_clear) m_err[i] = 1'b0;
          if (req_valid && req_gnt && cnt < ((i == 0) ? D0 : D1))
            mq[i].push_back(int'(req_idx));
        end
      end
    end
  end

  // Every-cycle comparison of both instances against their models.
  initial begin
    forever begin
      @(negedge clk);
      chk("rv0",    32'(rv0),    32'(m_rv[0]));
      chk("rd0",    rd0,         m_rd[0]);
      chk("opc0",   32'(opc0),   32'(m_opc[0]));
      chk("err0",   32'(err0),   32'(m_err[0]));
      chk("cnt0",   32'(out0),   32'(mq[0].size()));
      chk("stall0", 32'(stall0), 32'(mq[0].size() == D0));
      chk("rv1",    32'(rv1),    32'(m_rv[1]));
      chk("rd1",    rd1,         m_rd[1]);
      chk("opc1",   32'(opc1),   32'(m_opc[1]));
      chk("err1",   32'(err1),   32'(m_err[1]));
      chk("cnt1",   32'(out1),   32'(mq[1].size()));
      chk("stall1", 32'(stall1), 32'(mq[1].size() == D1));
    end
  end

  task automatic idle();
    req_valid = 1'b0; req_gnt = 1'b0; req_idx = '0;
    per_valid = '0; per_opc = '0; err_clear = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push(input int idx);
    req_valid = 1'b1; req_gnt = 1'b1; req_idx = 3'(idx);
    cyc(); idle();
  endtask

  task automatic resp(input int idx, input logic [DW-1:0] d, input logic opc);
    per_valid[idx] = 1'b1;
    per_rdata[idx*DW +: DW] = d;
    per_opc[idx] = opc;
    cyc(); idle();
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    cyc(); idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int idx;
    per_rdata = '0;
    idle();
    #1 rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_rv", 32'(rv0), 32'd0);
    chk("rst_rd", rd0, 32'd0);
    chk("rst_cnt", 32'(out0), 32'd0);
    chk("rst_stall", 32'(stall0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    #2 rst_n = 1'b1;
    cyc();

    // Single request with a one-cycle gap before the response.
    push(3);
    chk("t1_cnt_push", 32'(out0), 32'd1);
    cyc();
    resp(3, 32'hDEADBEEF, 1'b0);
    chk("t1_rv", 32'(rv0), 32'd1);
    chk("t1_rd", rd0, 32'hDEADBEEF);
    chk("t1_opc", 32'(opc0), 32'd0);
    chk("t1_cnt_pop", 32'(out0), 32'd0);
    cyc();
    chk("t1_rv_low", 32'(rv0), 32'd0);
    chk("t1_rd_hold", rd0, 32'hDEADBEEF);

    // Ordering across ports.
    push(1); push(5); push(2);
    resp(1, 32'd1, 1'b0); chk("t2_rd1", rd0, 32'd1);
    resp(5, 32'd5, 1'b1); chk("t2_rd5", rd0, 32'd5); chk("t2_opc5", 32'(opc0), 32'd1);
    resp(2, 32'd2, 1'b0); chk("t2_rd2", rd0, 32'd2);
    chk("t2_err", 32'(err0), 32'd0);

    // Full behaviour.
    push(0); push(1); push(2); push(3);
    chk("t3_stall", 32'(stall0), 32'd1);
    chk("t3_cnt4", 32'(out0), 32'd4);
    push(7);
    chk("t3_no_push", 32'(out0), 32'd4);
    resp(0, 32'hA0, 1'b0);
    chk("t3_stall_drop", 32'(stall0), 32'd0);
    chk("t3_cnt3", 32'(out0), 32'd3);
    req_valid = 1'b1; req_gnt = 1'b1; req_idx = 3'd6;
    per_valid[1] = 1'b1; per_rdata[1*DW +: DW] = 32'hA1;
    cyc(); idle();
    chk("t3_pushpop_cnt", 32'(out0), 32'd3);
    chk("t3_pushpop_rd", rd0, 32'hA1);
    resp(2, 32'hA2, 1'b0); resp(3, 32'hA3, 1'b0); resp(6, 32'hA6, 1'b1);
    chk("t3_rd6", rd0, 32'hA6);
    chk("t3_drained", 32'(out0), 32'd0);
    chk("t3_err", 32'(err0), 32'd0);
    clear_err();

    // Out-of-order and empty responses.
    push(2);
    per_valid[6] = 1'b1; cyc(); idle();
    chk("t4_rv", 32'(rv0), 32'd0);
    chk("t4_err", 32'(err0), 32'd1);
    chk("t4_cnt", 32'(out0), 32'd1);
    resp(2, 32'hB2, 1'b0);
    clear_err();
    chk("t4_cleared", 32'(err0), 32'd0);
    per_valid[4] = 1'b1; cyc(); idle();
    chk("t4_empty_err", 32'(err0), 32'd1);
    clear_err();
    chk("t4_clear", 32'(err0), 32'd0);
    per_valid[4] = 1'b1; err_clear = 1'b1; cyc(); idle();
    chk("t4_set_wins", 32'(err0), 32'd1);
    clear_err();

    // Wrap-around with random indices.
    for (int n = 0; n < 10; n++) begin
      idx = int'($urandom_range(0, N - 1));
      d = $urandom;
      push(idx);
      resp(idx, d, 1'(($urandom_range(0, 1))));
      chk("t5_rd", rd0, d);
      chk("t5_rd_d3", rd1, d);
    end
    chk("t5_err0", 32'(err0), 32'd0);
    chk("t5_err1", 32'(err1), 32'd0);

    // Reset mid-flight.
    push(4); push(5);
    #2 rst_n = 1'b0;
    cyc();
    chk("t6_rst_cnt", 32'(out0), 32'd0);
    chk("t6_rst_rd", rd0, 32'd0);
    chk("t6_rst_stall", 32'(stall0), 32'd0);
    cyc();
    #2 rst_n = 1'b1;
    cyc();
    resp(4, 32'hC4, 1'b0);
    chk("t6_rv", 32'(rv0), 32'd0);
    chk("t6_err", 32'(err0), 32'd1);
    clear_err();

    // Randomized traffic: mostly in-order responses, occasional stray bits.
    for (int n = 0; n < 600; n++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_gnt   = 1'($urandom_range(0, 1));
      req_idx   = 3'($urandom_range(0, N - 1));
      per_opc   = N'($urandom);
      for (int k = 0; k < N; k++) per_rdata[k*DW +: DW] = $urandom;
      per_valid = '0;
      if (mq[0].size() != 0 && $urandom_range(0, 2) != 0) per_valid[mq[0][0]] = 1'b1;
      if ($urandom_range(0, 24) == 0) per_valid[$urandom_range(0, N - 1)] = 1'b1;
      err_clear = ($urandom_range(0, 9) == 0);
      cyc();
    end
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/per_resp_tracker.md
# per_resp_tracker

Response-side companion to the cluster peripheral-interconnect address decoder. It records, in issue order, the peripheral index of every request the core-side master gets granted. It then steers the matching response from the PE_XBAR_N_OUPS peripheral ports back to the master as one registered response stream. It sits between the peripheral crossbar outputs and one master port, and enforces in-order return by bounding the number of outstanding transactions.

## Interface
- PE_XBAR_N_OUPS, 8: number of peripheral ports; IDX_W = $clog2(PE_XBAR_N_OUPS).
- MAX_OUTSTANDING, 4: tracker depth; must be ≥ 1. CNT_W = $clog2(MAX_OUTSTANDING+1).
- DATA_WIDTH, 32: response data width.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  master request toward crossbar, already gated by req_stall_o.
- req_pe_idx_i  in  IDX_W  decoded peripheral index of the current request.
- req_gnt_i  in  1  grant from the selected peripheral; request accepted when req_valid_i & req_gnt_i.
- req_stall_o  out  1  tracker full; master must hold req_valid_i low.
- per_r_valid_i  in  PE_XBAR_N_OUPS  per-peripheral response valid.
- per_r_rdata_i  in  PE_XBAR_N_OUPS*DATA_WIDTH  per-peripheral response data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- per_r_opc_i  in  PE_XBAR_N_OUPS  per-peripheral error flag.
- r_valid_o  out  1  response to master.
- r_rdata_o  out  DATA_WIDTH  response data.
- r_opc_o  out  1  response error flag.
- outstanding_o  out  CNT_W  current number of tracked requests.
- err_clear_i  in  1  synchronous clear of err_unexpected_o.
- err_unexpected_o  out  1  sticky flag: a response arrived that did not match the FIFO head.

## Operation
- The tracker is a circular FIFO of IDX_W entries, depth MAX_OUTSTANDING, with write pointer, read pointer and count. Pointers wrap from MAX_OUTSTANDING-1 to 0, including for non-power-of-2 depths.
- **Push:** on an accepted request (req_valid_i & req_gnt_i & ~full), store req_pe_idx_i at the write pointer.
- **Head:** the entry at the read pointer. It is valid only when count ≠ 0 and is taken from registered state only.
- **Pop:** when count ≠ 0 and per_r_valid_i[head] = 1, capture per_r_rdata_i[head] and per_r_opc_i[head] into the output registers, then advance the read pointer.
- **Simultaneous push and pop:** both occur; count is unchanged; the pointers advance independently.
- **Full:** count == MAX_OUTSTANDING. req_stall_o = full, combinational from the count only. A request presented while full is not pushed, even if req_gnt_i = 1, and err_unexpected_o is not set for it. Pushing into a full FIFO in the same cycle as a pop is not supported.
- **Unexpected response:** any per_r_valid_i bit set other than the head bit, or any bit set while count = 0.
  - The response is dropped.
  - err_unexpected_o is set on the next edge.
  - A valid head response arriving in the same cycle is still popped normally.
  - A response arriving in the same cycle as the push of its own request counts as unexpected.
- **Error flag:** err_unexpected_o holds until err_clear_i. If clear and a new unexpected event occur in the same cycle, set wins.
- outstanding_o = count.

## Timing
- **Reset values:** r_valid_o = 0, r_rdata_o = 0, r_opc_o = 0, err_unexpected_o = 0, outstanding_o = 0, req_stall_o = 0; pointers = 0.
- **Reset mid-operation:** all tracked entries are discarded. Responses to pre-reset requests arriving after reset are flagged as unexpected.
- **Response latency:** exactly 1 cycle from per_r_valid_i[head] to r_valid_o. r_valid_o is high for one cycle per pop, with no backpressure toward the master.
- **Throughput:** back-to-back pops give r_valid_o on consecutive cycles.
- **Counters:** count and req_stall_o update on the edge after the push or pop. A push becomes the head no earlier than the following cycle.
- **Output hold:** r_rdata_o and r_opc_o hold their last value when r_valid_o = 0.

## Test plan
1. **Single request.** Reset, then push idx 3 with grant. Two cycles later, per_r_valid_i[3] = 1 with rdata 0xDEADBEEF.
   -> r_valid_o = 1 one cycle later with r_rdata_o = 0xDEADBEEF and r_opc_o = 0; outstanding_o goes 0 → 1 → 0.
2. **Ordering across ports.** Push idx 1, 5, 2. Respond on 1, then 5, then 2, with data equal to the index.
   -> r_rdata_o returns 1, 5, 2 in order; err_unexpected_o stays 0.
3. **Full.** With MAX_OUTSTANDING = 4, push 4 requests.
   -> req_stall_o = 1 and outstanding_o = 4.
   - A fifth request granted while full is not pushed.
   - One pop drops req_stall_o on the next cycle.
   - A simultaneous push and pop at count 3 keeps count at 3.
4. **Out-of-order / empty responses.**
   - Head is idx 2 and per_r_valid_i[6] = 1 -> no r_valid_o, err_unexpected_o = 1 next cycle, count unchanged.
   - Response while empty -> err_unexpected_o set.
   - err_clear_i -> flag returns to 0.
5. **Wrap-around.** Run 10 push/pop pairs with random indices at MAX_OUTSTANDING = 3.
   -> all responses return in order with no error; pointers wrap correctly.
6. **Reset mid-flight.** Push 2 requests, assert rst_ni low, release, then respond on the first index.
   -> outputs are at reset values during reset; the response is flagged unexpected and r_valid_o stays 0.
